deserializer: RTL and testbench
===============================

# deserializer

Serial-to-parallel converter: the receive end of the team's 8-bit serializer link. It samples one qualified serial bit per clock, assembles WIDTH-bit words MSB-first (or LSB-first) and presents each completed word on a valid/ready output register. It sits between the serial line front-end and the parallel consumer, and flags dropped words and frame re-alignments.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in Data_out[WIDTH-1]; 0 = first bit lands in Data_out[0].
- clock_in  input  1  single clock; all logic on the rising edge.
- reset_n  input  1  reset; synchronous, active-low.
- Data_in  input  1  serial data bit.
- Data_in_valid  input  1  Data_in is sampled only on edges where this is 1.
- frame_start  input  1  qualified by Data_in_valid; marks the current bit as bit 0 of a new word.
- Data_out  output  WIDTH  assembled word; stable while Data_out_valid=1 and Data_out_ready=0.
- Data_out_valid  output  1  Data_out holds an unconsumed word.
- Data_out_ready  input  1  consumer accepts the word on an edge where valid and ready are both 1.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- sync_error  output  1  one-cycle pulse: frame_start arrived with a partial word pending.

## Operation
- State: shift register sh[WIDTH-1:0], bit counter cnt (clog2(WIDTH) bits, 0..WIDTH-1), output register Data_out, flag Data_out_valid.
- Reset (reset_n=0 at an edge): cnt=0, sh=0, Data_out=0, Data_out_valid=0, overrun=0, sync_error=0. Any partial word and any held word are discarded. Other inputs are ignored during reset.
- Bit accept: an edge with Data_in_valid=1. Edges with Data_in_valid=0 change nothing except pulse clearing and output drain.
- MSB_FIRST=1: sh <= {sh[WIDTH-2:0], Data_in}. MSB_FIRST=0: sh <= {Data_in, sh[WIDTH-1:1]}.
- cnt increments per accepted bit. The bit accepted at cnt=WIDTH-1 completes the word, and cnt wraps to 0.
- frame_start=1 with Data_in_valid=1: the partial word is discarded, this bit is treated as bit 0, and cnt becomes 1. If cnt was non-zero beforehand, sync_error pulses. frame_start with Data_in_valid=0 is ignored.
- Word completion: the completed word is the value sh holds after the shift. On the same edge:
  - If the output slot is free (Data_out_valid=0, or Data_out_valid=1 and Data_out_ready=1), load Data_out with the word and set Data_out_valid=1.
  - Otherwise the new word is dropped, Data_out and Data_out_valid are left unchanged, and overrun pulses.
- Drain: valid and ready both 1 with no completion on that edge clears Data_out_valid. Data_out keeps its last value.
- Simultaneous drain and completion is a back-to-back transfer: valid stays 1, Data_out takes the new word, and there is no overrun.
- overrun and sync_error are registered, high for exactly one cycle per event, and otherwise 0.
- WIDTH=1 is unsupported.

## Timing
- Latency: the word whose last bit is accepted at edge N is visible on Data_out with Data_out_valid=1 from just after edge N. Latency is one edge from the final bit, with no extra pipeline.
- Throughput: one word per WIDTH accepted bits, sustained with Data_out_ready held at 1. Gaps in Data_in_valid stretch assembly time without losing state.
- The consumer has a full WIDTH-bit accept window to drain before an overrun can occur.
- Data_out_ready is allowed to be 1 while valid is 0; it has no effect.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Basic MSB-first: after reset, send 1,0,1,1,0,1,0,1 on consecutive edges with ready=1 -> Data_out=8'hB5 with valid high for 1 cycle after the 8th edge. overrun=0, sync_error=0.
- LSB-first (MSB_FIRST=0): same bit sequence -> Data_out=8'hAD.
- Gapped input: 8'hB5 sent with Data_in_valid toggling 1/0 -> same 8'hB5. valid asserts one edge after the 8th qualified bit.
- Backpressure/overrun: ready=0, send 8'hB5 then 8'h3C -> Data_out stays 8'hB5 and overrun pulses at the 16th bit. Then ready=1 for one edge -> valid=0.
- Back-to-back: ready held at 1, send 8'hB5, 8'h3C, 8'hFF continuously -> three words on consecutive 8-bit boundaries, with valid held high only in the completion cycles and no overrun.
- Resync and reset: 3 bits sent, then frame_start with the first bit of 8'hA5 -> sync_error pulses once and Data_out=8'hA5. Separately, assert reset_n=0 after 4 bits, then send 8'h5A -> Data_out=8'h5A and all outputs were 0 during reset.

Source files
------------

// File: rtl/deserializer_if.sv
// Parallel-side bundle of the serial receiver: qualified serial bit in, word out
// on a valid/ready register, plus the overrun / sync_error event pulses.
interface deserializer_if #(
    parameter int WIDTH = 8
);
    logic             Data_in;
    logic             Data_in_valid;
    logic             frame_start;
    logic [WIDTH-1:0] Data_out;
    logic             Data_out_valid;
    logic             Data_out_ready;
    logic             overrun;
    logic             sync_error;

    // master = line front-end + consumer, slave = the deserializer itself
    modport master (
        output Data_in, Data_in_valid, frame_start, Data_out_ready,
        input  Data_out, Data_out_valid, overrun, sync_error
    );

    modport slave (
        input  Data_in, Data_in_valid, frame_start, Data_out_ready,
        output Data_out, Data_out_valid, overrun, sync_error
    );
endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: shifts in one qualified bit per edge, assembles
// WIDTH-bit words (MSB- or LSB-first) and hands them out on a valid/ready register.
module deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic           clock_in,
    input logic           reset_n,
    deserializer_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh, sh_base, sh_next;
    logic [CW-1:0]    cnt, cnt_base, cnt_next;
    logic             accept, done, slot_free, drain;

    // frame_start restarts assembly from an empty shifter, so this bit is bit 0
    always_comb begin
        accept    = bus.Data_in_valid;
        cnt_base  = bus.frame_start ? '0 : cnt;
        sh_base   = bus.frame_start ? '0 : sh;
        sh_next   = '0;
        if (MSB_FIRST) sh_next = {sh_base[WIDTH-2:0], bus.Data_in};
        else           sh_next = {bus.Data_in, sh_base[WIDTH-1:1]};
        cnt_next  = (cnt_base == LAST) ? '0 : cnt_base + CW'(1);
        done      = accept && (cnt_base == LAST);
        slot_free = !bus.Data_out_valid || bus.Data_out_ready;
        drain     = bus.Data_out_valid && bus.Data_out_ready;
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            sh                 <= '0;
            cnt                <= '0;
            bus.Data_out       <= '0;
            bus.Data_out_valid <= 1'b0;
            bus.overrun        <= 1'b0;
            bus.sync_error     <= 1'b0;
        end else begin
            bus.overrun    <= 1'b0;
            bus.sync_error <= 1'b0;
            if (accept) begin
                sh             <= sh_next;
                cnt            <= cnt_next;
                bus.sync_error <= bus.frame_start && (cnt != '0);
            end
            // a completion into a freed slot is a back-to-back transfer: valid stays up
            if (done && slot_free) begin
                bus.Data_out       <= sh_next;
                bus.Data_out_valid <= 1'b1;
            end else begin
                if (done)  bus.overrun        <= 1'b1;
                if (drain) bus.Data_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_deserializer.sv
// Directed vector bench for deserializer: an MSB-first and an LSB-first instance
// share one stimulus stream; a vector table plus hand sequences for reset handling.
module tb_deserializer;
    logic clock_in = 1'b0;
    logic reset_n  = 1'b0;
    always #5 clock_in = ~clock_in;

    deserializer_if #(.WIDTH(8)) bus_m ();
    deserializer_if #(.WIDTH(8)) bus_l ();

    assign bus_l.Data_in        = bus_m.Data_in;
    assign bus_l.Data_in_valid  = bus_m.Data_in_valid;
    assign bus_l.frame_start    = bus_m.frame_start;
    assign bus_l.Data_out_ready = bus_m.Data_out_ready;

    deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .bus      (bus_m)
    );

    deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .bus      (bus_l)
    );

    typedef struct {
        logic       din, vld, fs, rdy;
        logic       ev, eo, es, chk, chkl;
        logic [7:0] ed, el;
    } vec_t;

    vec_t vq[$];
    int   nvec = 0;
    int   nmis = 0;

    task automatic push(input logic din, vld, fs, rdy, ev, eo, es, chk,
                        input logic [7:0] ed, input logic chkl, input logic [7:0] el);
        vec_t v;
        v.din = din; v.vld = vld; v.fs = fs; v.rdy = rdy;
        v.ev = ev; v.eo = eo; v.es = es; v.chk = chk; v.ed = ed;
        v.chkl = chkl; v.el = el;
        vq.push_back(v);
    endtask

    task automatic idle(input logic rdy, ev, chk, input logic [7:0] ed);
        push(1'b0, 1'b0, 1'b0, rdy, ev, 1'b0, 1'b0, chk, ed, 1'b0, 8'h00);
    endtask

    // eight bits of w, sent MSB of w first; expectations are hand-supplied
    task automatic add_word(input logic [7:0] w, input logic rdy, rdy_last, gap, fs1, es1,
                            ev_mid, ev_last, eo_last, input logic [7:0] ed_last,
                            input logic chkl, input logic [7:0] el);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0)
                push(w[i], 1'b1, 1'b0, rdy_last, ev_last, eo_last, 1'b0, 1'b1, ed_last, chkl, el);
            else
                push(w[i], 1'b1, (i == 7) ? fs1 : 1'b0, rdy, ev_mid, 1'b0,
                     (i == 7) ? es1 : 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            if (gap && i != 0) idle(rdy, ev_mid, 1'b0, 8'h00);
        end
    endtask

    task automatic drive(input logic din, vld, fs, rdy);
        bus_m.Data_in        = din;
        bus_m.Data_in_valid  = vld;
        bus_m.frame_start    = fs;
        bus_m.Data_out_ready = rdy;
        @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string nm, input logic ev, eo, es, chk, input logic [7:0] ed,
                         input logic chkl, input logic [7:0] el);
        logic bad;
        nvec++;
        bad = (bus_m.Data_out_valid !== ev) || (bus_m.overrun !== eo) ||
              (bus_m.sync_error !== es) || (chk && bus_m.Data_out !== ed) ||
              (chkl && bus_l.Data_out !== el);
        if (bad) begin
            nmis++;
            $display("FAIL %s: got v=%b d=%h o=%b s=%b l=%h, want v=%b d=%h o=%b s=%b l=%h (chk=%b chkl=%b)",
                     nm, bus_m.Data_out_valid, bus_m.Data_out, bus_m.overrun, bus_m.sync_error,
                     bus_l.Data_out, ev, ed, eo, es, el, chk, chkl);
        end
    endtask

    initial begin
        // basic MSB-first / LSB-first, then drain
        add_word(8'hB5, 1, 1, 0, 0, 0, 0, 1, 0, 8'hB5, 1, 8'hAD);
        idle(1, 0, 1, 8'hB5);
        // gapped Data_in_valid
        add_word(8'hB5, 1, 1, 1, 0, 0, 0, 1, 0, 8'hB5, 1, 8'hAD);
        idle(1, 0, 1, 8'hB5);
        // backpressure: second word dropped, held word survives, then drained
        add_word(8'hB5, 0, 0, 0, 0, 0, 0, 1, 0, 8'hB5, 0, 8'h00);
        add_word(8'h3C, 0, 0, 0, 0, 0, 1, 1, 1, 8'hB5, 0, 8'h00);
        idle(1, 0, 1, 8'hB5);
        // back-to-back with ready held high
        add_word(8'hB5, 1, 1, 0, 0, 0, 0, 1, 0, 8'hB5, 1, 8'hAD);
        add_word(8'h3C, 1, 1, 0, 0, 0, 0, 1, 0, 8'h3C, 1, 8'h3C);
        add_word(8'hFF, 1, 1, 0, 0, 0, 0, 1, 0, 8'hFF, 1, 8'hFF);
        idle(1, 0, 1, 8'hFF);
        // held word drained on the very edge the next word completes
        add_word(8'hB5, 0, 0, 0, 0, 0, 0, 1, 0, 8'hB5, 0, 8'h00);
        add_word(8'h3C, 0, 1, 0, 0, 0, 1, 1, 0, 8'h3C, 0, 8'h00);
        idle(1, 0, 1, 8'h3C);
        // resync: 3 partial bits, unqualified frame_start ignored, then realign
        push(1, 1, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        push(1, 1, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        push(0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        push(0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        add_word(8'hA5, 1, 1, 0, 1, 1, 0, 1, 0, 8'hA5, 1, 8'hA5);
        // frame_start on an aligned boundary is not an error
        add_word(8'h3C, 1, 1, 0, 1, 0, 0, 1, 0, 8'h3C, 1, 8'h3C);
        idle(1, 0, 1, 8'h3C);

        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("reset_state", 0, 0, 0, 1, 8'h00, 1, 8'h00);
        reset_n = 1'b1;

        foreach (vq[k]) begin
            drive(vq[k].din, vq[k].vld, vq[k].fs, vq[k].rdy);
            check($sformatf("vec%0d", k), vq[k].ev, vq[k].eo, vq[k].es, vq[k].chk, vq[k].ed,
                  vq[k].chkl, vq[k].el);
        end

        // reset mid-stream with a held word and a partial word pending
        for (int i = 7; i >= 0; i--) drive(8'hB5 >> i, 1, 0, 0);
        check("hold_pre_rst", 1, 0, 0, 1, 8'hB5, 1, 8'hAD);
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
        reset_n = 1'b0;
        drive(1, 1, 1, 1);
        check("in_reset", 0, 0, 0, 1, 8'h00, 1, 8'h00);
        reset_n = 1'b1;
        for (int i = 7; i >= 1; i--) drive(8'h5A >> i, 1, 0, 1);
        check("post_rst_7b", 0, 0, 0, 1, 8'h00, 1, 8'h00);
        drive(1'b0, 1, 0, 1);
        check("post_rst_5A", 1, 0, 0, 1, 8'h5A, 1, 8'h5A);
        drive(0, 0, 0, 1);
        check("post_rst_drain", 0, 0, 0, 1, 8'h5A, 1, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
